// File: rtl/fir_input_feeder.sv
// Buffers upstream samples in a FIFO and paces them one at a time into a serial FIR.
// Define FIR_FEEDER_TIMEOUT_EN to enable the WAIT-state watchdog and timeout_err.
module fir_input_feeder #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter int SETUP   = 5,
   parameter int TIMEOUT = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [WIDTH-1:0]         fir_data,
   output logic                     fir_valid,
   input  logic                     fir_done,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (SETUP > 1) ? $clog2(SETUP) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_WAIT
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    setup_cnt;
   logic             fir_done_q;
   logic             done_edge;
   logic             push;
   logic             pop;
   logic             timeout_hit;

   assign s_ready   = (level != LW'(DEPTH)) && rst;
   assign push      = s_valid && s_ready;
   assign pop       = (state == S_IDLE) && (level != '0);
   assign done_edge = fir_done && !fir_done_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
      end
   end

   // fir_data holds the popped sample until the next pop
   always_ff @(posedge clk) begin
      if (!rst) begin
         fir_data   <= '0;
         setup_cnt  <= '0;
         fir_done_q <= 1'b0;
      end else begin
         fir_done_q <= fir_done;
         if (pop) begin
            fir_data  <= mem[rd_ptr];
            setup_cnt <= CW'(SETUP - 1);
         end else if (state == S_SETUP && setup_cnt != '0) begin
            setup_cnt <= setup_cnt - 1'b1;
         end
      end
   end

`ifdef FIR_FEEDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wait_cnt;
   logic          timeout_q;

   // an edge in the final WAIT cycle wins over the watchdog
   assign timeout_hit = (state == S_WAIT) && !done_edge &&
                        (wait_cnt == TW'(TIMEOUT - 1));
   assign timeout_err = timeout_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
         else                 wait_cnt <= '0;
         if (timeout_hit) timeout_q <= 1'b1;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT;

   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (pop) state_nx = S_SETUP;
         S_SETUP: if (setup_cnt == '0) state_nx = S_PULSE;
         S_PULSE: state_nx = S_WAIT;
         S_WAIT:  if (done_edge || timeout_hit) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      fir_valid = (state == S_PULSE);
      busy      = (state != S_IDLE);
   end

endmodule
